// File: rtl/data_generate_burst.sv
// rtl/data_generate_burst.sv - burst pattern generator (inc/dec/walking-ones, PRBS under DATA_GEN_PRBS_EN)
// Data register persists across bursts; it is only rewritten by a seed load, a start fix-up or an accepted beat.
module data_generate_burst #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 64,
    parameter int BCNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_step,
    input  logic              i_seed_load,
    input  logic [DATA_W-1:0] i_seed,
    input  logic              i_ready,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [BCNT_W-1:0] o_burst_cnt
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

`ifdef DATA_GEN_PRBS_EN
    localparam logic [DATA_W-1:0] PRBS_TAPS = DATA_W'(32'h0040_0007);
    localparam bit PRBS_ON = 1'b1;
    generate
        if (DATA_W != 32) begin : g_prbs_width_check
            $error("data_generate_burst: PRBS build requires DATA_W == 32");
        end
    endgenerate
`else
    localparam bit PRBS_ON = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   beat_q;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  step_q;
    logic               done_q;
    logic [BCNT_W-1:0]  bcnt_q;

    logic               accept;
    logic               is_last;
    logic [DATA_W-1:0]  seed_sel;
    logic [DATA_W-1:0]  start_val;
    logic               zero_guard;

    function automatic logic [DATA_W-1:0] advance(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [DATA_W-1:0] step);
        logic [DATA_W-1:0] r;
        case (mode)
            2'b01:   r = d - step;
            2'b10:   r = {d[DATA_W-2:0], d[DATA_W-1]};
`ifdef DATA_GEN_PRBS_EN
            2'b11:   r = {d[DATA_W-2:0], 1'b0} ^ (d[DATA_W-1] ? PRBS_TAPS : '0);
`endif
            default: r = d + step;
        endcase
        return r;
    endfunction

    assign accept  = (state_q == RUN) && i_ready;
    assign is_last = (beat_q == LAST_BEAT);

    // Walking-ones and PRBS would stay stuck at zero, so the first word is forced to 1.
    assign seed_sel   = i_seed_load ? i_seed : data_q;
    assign zero_guard = (i_mode == 2'b10) || (PRBS_ON && (i_mode == 2'b11));
    assign start_val  = (zero_guard && (seed_sel == '0)) ? DATA_W'(1) : seed_sel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (accept && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
            beat_q <= '0;
            mode_q <= '0;
            step_q <= '0;
            done_q <= 1'b0;
            bcnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (i_start) begin
                    mode_q <= i_mode;
                    step_q <= i_step;
                    data_q <= start_val;
                    beat_q <= '0;
                end else if (i_seed_load) begin
                    data_q <= i_seed;
                end
            end else if (accept) begin
                data_q <= advance(mode_q, data_q, step_q);
                if (is_last) begin
                    beat_q <= '0;
                    done_q <= 1'b1;
                    if (bcnt_q != '1) bcnt_q <= bcnt_q + BCNT_W'(1);
                end else begin
                    beat_q <= beat_q + CNT_W'(1);
                end
            end
        end
    end

    assign o_data_valid = (state_q == RUN);
    assign o_busy       = (state_q == RUN);
    assign o_data       = data_q;
    assign o_last       = (state_q == RUN) && is_last;
    assign o_done       = done_q;
    assign o_burst_cnt  = bcnt_q;

endmodule

// File: tb/tb_data_generate_burst.sv
// tb/tb_data_generate_burst.sv - self-checking bench for data_generate_burst
module tb_data_generate_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] step;
    logic        seed_load;
    logic [31:0] seed;
    logic        ready;
    logic        valid, last, busy, done;
    logic [31:0] data;
    logic [15:0] bcnt;

    logic        s_start, s_ready, s_valid, s_last, s_busy, s_done;
    logic [7:0]  s_data;
    logic [1:0]  s_bcnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_generate_burst #(.DATA_W(32), .BURST_LEN(64), .BCNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
        .i_seed_load(seed_load), .i_seed(seed), .i_ready(ready),
        .o_data_valid(valid), .o_data(data), .o_last(last), .o_busy(busy),
        .o_done(done), .o_burst_cnt(bcnt)
    );

    data_generate_burst #(.DATA_W(8), .BURST_LEN(4), .BCNT_W(2)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_mode(2'b00), .i_step(8'd1),
        .i_seed_load(1'b0), .i_seed(8'd0), .i_ready(s_ready),
        .o_data_valid(s_valid), .o_data(s_data), .o_last(s_last), .o_busy(s_busy),
        .o_done(s_done), .o_burst_cnt(s_bcnt)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] step;
        logic        sload;
        logic [31:0] seed;
        logic [31:0] exp[6];
    } vec_t;

    vec_t vecs[7];
    int   chk_idx[6] = '{0, 1, 2, 3, 32, 63};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] prbs_next(input logic [31:0] d);
        logic [31:0] r;
        r = {d[30:0], 1'b0};
        if (d[31]) r = r ^ 32'h0040_0007;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] m, input logic [31:0] st, input logic sl,
                          input logic [31:0] sd);
        start = 1'b1; mode = m; step = st; seed_load = sl; seed = sd;
        tick();
        start = 1'b0; seed_load = 1'b0;
        chk("latency_valid", 32'(valid), 32'd1);
        chk("latency_busy", 32'(busy), 32'd1);
    endtask

    task automatic run_vec(input int v);
        int k;
        launch(vecs[v].mode, vecs[v].step, vecs[v].sload, vecs[v].seed);
        k = 0;
        for (int b = 0; b < 64; b++) begin
            if (k < 6 && chk_idx[k] == b) begin
                chk($sformatf("vec%0d_beat%0d", v, b), data, vecs[v].exp[k]);
                k++;
            end
            chk($sformatf("vec%0d_last%0d", v, b), 32'(last), 32'(b == 63));
            tick();
        end
        chk($sformatf("vec%0d_valid_end", v), 32'(valid), 32'd0);
        chk($sformatf("vec%0d_done", v), 32'(done), 32'd1);
        chk($sformatf("vec%0d_bcnt", v), 32'(bcnt), 32'(v + 1));
        tick();
        chk($sformatf("vec%0d_done_fall", v), 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] prev_data;
        logic        prev_last, prev_stall;
        int          acc, cyc, nd, last_done_cyc;
        logic [7:0]  s_exp;

        vecs[0] = '{2'b00, 32'd1, 1'b0, 32'd0, '{32'd0, 32'd1, 32'd2, 32'd3, 32'd32, 32'd63}};
        vecs[1] = '{2'b00, 32'd1, 1'b0, 32'd0, '{32'd64, 32'd65, 32'd66, 32'd67, 32'h60, 32'h7F}};
        vecs[2] = '{2'b00, 32'd1, 1'b1, 32'hFFFF_FFFE,
                    '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h1E, 32'h3D}};
        vecs[3] = '{2'b01, 32'd3, 1'b1, 32'd5,
                    '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFA5, 32'hFFFF_FF48}};
        vecs[4] = '{2'b10, 32'd0, 1'b1, 32'd0,
                    '{32'd1, 32'd2, 32'd4, 32'd8, 32'd1, 32'h8000_0000}};
        vecs[5] = '{2'b11, 32'd2, 1'b0, 32'd0, '{32'd1, 32'd3, 32'd5, 32'd7, 32'h41, 32'h7F}};
        vecs[6] = '{2'b11, 32'd2, 1'b1, 32'd0, '{32'd0, 32'd2, 32'd4, 32'd6, 32'h40, 32'h7E}};
`ifdef DATA_GEN_PRBS_EN
        for (int v = 5; v < 7; v++) begin
            int k;
            d = 32'd1;
            k = 0;
            for (int b = 0; b < 64; b++) begin
                if (k < 6 && chk_idx[k] == b) begin
                    vecs[v].exp[k] = d;
                    k++;
                end
                d = prbs_next(d);
            end
        end
`endif

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; step = 32'd0; seed_load = 1'b0;
        seed = 32'd0; ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcnt", 32'(bcnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", 32'(valid), 32'd0);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Reset in the middle of a burst: abandoned, no completion pulse.
        launch(2'b00, 32'd1, 1'b0, 32'd0);
        for (int b = 0; b < 20; b++) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", data, 32'd0);
        chk("midrst_last", 32'(last), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcnt", 32'(bcnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_done_after", 32'(done), 32'd0);
        chk("midrst_valid_after", 32'(valid), 32'd0);

        // Control inputs pulsed during RUN must not disturb the burst.
        launch(2'b00, 32'd1, 1'b0, 32'd0);
        for (int b = 0; b < 64; b++) begin
            chk($sformatf("ign_beat%0d", b), data, 32'(b));
            if (b == 5) begin
                start = 1'b1; mode = 2'b01; step = 32'd7; seed_load = 1'b1; seed = 32'hAAAA;
            end else begin
                start = 1'b0; seed_load = 1'b0;
            end
            tick();
        end
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_bcnt", 32'(bcnt), 32'd1);
        tick();

        // Backpressure: held words stay stable, exactly 64 accepted in order.
        launch(2'b00, 32'd1, 1'b1, 32'd0);
        acc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (cyc = 0; cyc < 1000 && acc < 64; cyc++) begin
            if (prev_stall) begin
                chk("bp_hold_data", data, prev_data);
                chk("bp_hold_last", 32'(last), 32'(prev_last));
            end
            ready = (($urandom_range(0, 3) == 0) || (cyc % 4 == 0) || (cyc % 4 == 3));
            prev_data = data; prev_last = last;
            prev_stall = !ready;
            if (ready && valid) begin
                chk("bp_word", data, 32'(acc));
                chk("bp_last", 32'(last), 32'(acc == 63));
                acc++;
            end
            tick();
        end
        ready = 1'b1;
        chk("bp_accepted", 32'(acc), 32'd64);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_valid_end", 32'(valid), 32'd0);
        chk("bp_bcnt", 32'(bcnt), 32'd2);
        tick();

        // Small instance: start held high -> back-to-back bursts, saturating counter.
        s_start = 1'b1;
        s_exp = 8'd0; nd = 0; last_done_cyc = 0;
        for (cyc = 0; cyc < 60 && nd < 5; cyc++) begin
            if (s_valid) begin
                chk("s_word", 32'(s_data), 32'(s_exp));
                chk("s_last", 32'(s_last), 32'(s_exp[1:0] == 2'b11));
                s_exp++;
            end
            if (s_done) begin
                nd++;
                chk($sformatf("s_bcnt%0d", nd), 32'(s_bcnt), 32'((nd > 3) ? 3 : nd));
                if (nd > 1) chk("s_period", 32'(cyc - last_done_cyc), 32'd5);
                chk("s_done_valid", 32'(s_valid), 32'd0);
                last_done_cyc = cyc;
            end
            tick();
        end
        chk("s_bursts", 32'(nd), 32'd5);
        s_start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_generate_burst.md
Name: data_generate_burst

Overview:
- Parametrised successor to the incremental data generator.
- Produces bursts of BURST_LEN words of DATA_W bits on a valid/ready stream, with selectable pattern mode, programmable seed/step and downstream backpressure.
- Sits between the control sequencer (start/seed/mode) and the RAM write path.
- Data continues from the previous burst's next value unless reseeded.

Parameters:
- DATA_W, 32, data word width (≥ 2).
- BURST_LEN, 64, words per burst (≥ 2); beat counter width is the localparam CNT_W = $clog2(BURST_LEN).
- BCNT_W, 16, width of the completed-burst counter.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_mode  in  2  pattern: 00 increment, 01 decrement, 10 walking-ones, 11 PRBS (see Optional Feature).
- i_step  in  DATA_W  increment/decrement amount; latched at start.
- i_seed_load  in  1  load i_seed into the data register; honoured only in IDLE.
- i_seed  in  DATA_W  seed value.
- i_ready  in  1  downstream ready.
- o_data_valid  out  1  o_data is valid.
- o_data  out  DATA_W  current word.
- o_last  out  1  marks the final beat of a burst; qualified by o_data_valid.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse after a burst completes.
- o_burst_cnt  out  BCNT_W  completed bursts; saturating.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is synchronous and active-low.
- Reset (i_rst_n=0 at an edge): all outputs 0, FSM to IDLE, data register 0, beat counter 0, latched mode/step 0. Applies mid-burst; the burst is abandoned with no o_done.
- FSM states: IDLE, RUN.
- IDLE -> RUN when i_start=1. Latch i_mode and i_step. o_data_valid and o_busy go high the next cycle (1 clk latency).
- In RUN, i_start, i_mode, i_step, i_seed_load and i_seed are ignored.
- Seed:
  - In IDLE, i_seed_load=1 writes i_seed to the data register.
  - If i_seed_load and i_start are both high in the same cycle, the seed is loaded and it is the first word of the burst.
- Beat accepted when o_data_valid & i_ready.
  - On accept: data register advances per mode; beat counter +1.
  - With no accept: o_data, o_last and the counter hold (AXI-stream style stability).
- Mode arithmetic, all modulo 2^DATA_W, silent wrap:
  - Increment: data + step.
  - Decrement: data − step.
  - Walking-ones: rotate left by 1. If the register is 0 on entering RUN in this mode, the first word is forced to 1.
  - Mode 11 without the PRBS build behaves as increment.
- Last beat:
  - o_last=1 while beat counter == BURST_LEN-1.
  - On that accept: beat counter -> 0, FSM -> IDLE, o_data_valid/o_busy -> 0, o_done=1 for exactly the next cycle, o_burst_cnt +1 (saturates at all-ones).
- The data register retains the post-advance value; the next burst continues from it.
- i_start coinciding with the o_done cycle is accepted; back-to-back bursts leave one idle cycle between bursts.

Optional Feature:
- Macro: DATA_GEN_PRBS_EN.
- Defined:
  - Mode 11 is PRBS-31-style Galois LFSR, polynomial x^32+x^22+x^2+x+1, shift left, feedback applied when the MSB is 1.
  - DATA_W must equal 32; any other width is an elaboration error.
  - A zero register on entering RUN is replaced by 1 (lock-up guard).
- Undefined: no LFSR logic; mode 11 aliases increment.

Test Plan:
1. Reset, then i_start, mode 00, step 1, i_ready=1 -> o_data_valid rises 1 clk later; words 0..63; o_last on word 63; o_done one cycle after the last beat; o_burst_cnt=1.
2. Second start, same mode -> words 64..127; seed_load 0xFFFFFFFE with start, step 1 -> words 0xFFFFFFFE, 0xFFFFFFFF, 0, 1…
3. Mode 01, step 3, seed 5 -> 5, 2, 0xFFFFFFFF, 0xFFFFFFFC…; mode 10 from data 0 -> 1, 2, 4…, 0x80000000, 1 (wrap after 32 beats).
4. i_ready toggled 1,0,0,1 pseudo-randomly -> o_data/o_last stable while stalled; exactly 64 accepted beats; no duplicates or skips.
5. Reset (i_rst_n=0) at beat 20 -> all outputs 0 next cycle, no o_done, o_burst_cnt=0; i_start during RUN ignored; o_burst_cnt saturates at 0xFFFF with BCNT_W=16.
6. With DATA_GEN_PRBS_EN, mode 11, seed 1 -> 2, 4, … then the feedback XOR pattern after MSB is set matches the reference model; seed 0 -> first word 1.
